// File: rtl/riscv_exec_pipe_if.sv
// riscv_exec_pipe_if: instruction-in / result-out handshake bundle for the exec pipe.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface riscv_exec_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            zero_flag;
    logic            bt;
    logic            illegal;
    logic [4:0]      rd_out;

    // Fetch / retire side
    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_result, zero_flag, bt, illegal, rd_out
    );

    // Pipeline side
    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alu_result, zero_flag, bt, illegal, rd_out
    );
endinterface

// File: rtl/riscv_exec_pipe.sv
// riscv_exec_pipe: two-stage RV-subset decode/execute with register writeback and operand bypass.
// Latency: instr accepted at edge N is presented on the outputs after edge N+1; 1 instr/clk sustained.
// Backpressure: S2 holds while out_ready is low, S1 stalls behind it and in_ready drops when both are full.
module riscv_exec_pipe #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    riscv_exec_pipe_if.slave bus
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [1:0] {K_R, K_I, K_B} kind_t;

    // Architectural register file; x0 is never written, reads of x0 are forced to 0
    logic [XLEN-1:0] regs [NREGS];

    // Decode fields of the instruction being offered
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm_x;

    assign opcode = bus.instr[6:0];
    assign f3     = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign rd     = bus.instr[11:7];
    assign imm_x  = XLEN'($signed(bus.instr[31:20]));

    function automatic logic idx_bad(input logic [4:0] idx);
        return int'(idx) >= NREGS;
    endfunction

    // Stage 1 state (decoded, operands resolved)
    logic            s1_valid;
    kind_t           s1_kind;
    logic [2:0]      s1_f3;
    logic [4:0]      s1_rd;
    logic            s1_illegal;
    logic [XLEN-1:0] s1_a, s1_b;

    // Stage 2 state (registered results)
    logic            s2_valid;
    logic [XLEN-1:0] s2_result;
    logic            s2_zero, s2_bt, s2_illegal;
    logic [4:0]      s2_rd;

    logic            s1_advance, s1_wen, accept;
    logic [XLEN-1:0] ex_result;
    logic            ex_zero, ex_bt;
    logic            cmp_lt, cmp_gt;

    kind_t           dec_kind;
    logic            dec_illegal;
    logic [XLEN-1:0] reg_a, reg_b, op_a, op_b;

    assign s1_advance = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_advance;
    assign accept     = bus.in_valid && bus.in_ready;
    assign s1_wen     = s1_valid && !s1_illegal && (s1_kind != K_B) && (s1_rd != 5'd0);

    // Classify the offered instruction; only register fields the format uses are range-checked
    always_comb begin
        dec_kind    = K_R;
        dec_illegal = 1'b1;
        case (opcode)
            OP_R: begin
                dec_kind    = K_R;
                dec_illegal = (f3 > 3'd4) || idx_bad(rs1) || idx_bad(rs2) || idx_bad(rd);
            end
            OP_I: begin
                dec_kind    = K_I;
                dec_illegal = (f3 > 3'd1) || idx_bad(rs1) || idx_bad(rd);
            end
            OP_B: begin
                dec_kind    = K_B;
                dec_illegal = (f3 > 3'd3) || idx_bad(rs1) || idx_bad(rs2);
            end
            default: begin
                dec_kind    = K_R;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Operand fetch; a writer leaving S1 on this same edge overrides the stale register value
    always_comb begin
        reg_a = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
        reg_b = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];
        op_a  = (s1_advance && s1_wen && (s1_rd == rs1)) ? ex_result : reg_a;
        op_b  = (s1_advance && s1_wen && (s1_rd == rs2)) ? ex_result : reg_b;
        if (dec_kind == K_I) begin
            op_b = imm_x;
        end
    end

    assign cmp_lt = SIGNED_CMP ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);
    assign cmp_gt = SIGNED_CMP ? ($signed(s1_a) > $signed(s1_b)) : (s1_a > s1_b);

    // Execute on S1 contents; illegal instructions produce all-zero results
    always_comb begin
        ex_result = '0;
        ex_zero   = 1'b0;
        ex_bt     = 1'b0;
        if (!s1_illegal) begin
            case (s1_kind)
                K_R: begin
                    case (s1_f3)
                        3'd0:    ex_result = s1_a + s1_b;
                        3'd1:    ex_result = s1_a - s1_b;
                        3'd2:    ex_result = s1_a | s1_b;
                        3'd3:    ex_result = s1_a & s1_b;
                        default: ex_result = s1_a ^ s1_b;
                    endcase
                end
                K_I: ex_result = (s1_f3 == 3'd0) ? (s1_a + s1_b) : (s1_a - s1_b);
                default: begin
                    ex_result = s1_a - s1_b;
                    case (s1_f3)
                        3'd0:    ex_bt = (s1_a == s1_b);
                        3'd1:    ex_bt = (s1_a != s1_b);
                        3'd2:    ex_bt = cmp_lt;
                        default: ex_bt = cmp_gt;
                    endcase
                end
            endcase
            ex_zero = (ex_result == '0);
        end
    end

    // S1 register: refills whenever it is empty or handing its instr to S2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_kind    <= K_R;
            s1_f3      <= 3'd0;
            s1_rd      <= 5'd0;
            s1_illegal <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_kind    <= dec_kind;
                s1_f3      <= f3;
                s1_rd      <= rd;
                s1_illegal <= dec_illegal;
                s1_a       <= op_a;
                s1_b       <= op_b;
            end
        end
    end

    // S2 register: result fields only change on a transfer so they hold steady under backpressure
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_bt      <= 1'b0;
            s2_illegal <= 1'b0;
            s2_rd      <= 5'd0;
        end else begin
            if (!s2_valid || bus.out_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_advance) begin
                s2_result  <= ex_result;
                s2_zero    <= ex_zero;
                s2_bt      <= ex_bt;
                s2_illegal <= s1_illegal;
                s2_rd      <= s1_rd;
            end
        end
    end

    // Writeback at the S1->S2 transfer edge; reset restores x[i] = i
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= XLEN'(i);
            end
        end else if (s1_advance && s1_wen) begin
            regs[s1_rd[RW-1:0]] <= ex_result;
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.alu_result = s2_result;
    assign bus.zero_flag  = s2_zero;
    assign bus.bt         = s2_bt;
    assign bus.illegal    = s2_illegal;
    assign bus.rd_out     = s2_rd;
endmodule

// File: tb/tb_riscv_exec_pipe.sv
// tb_riscv_exec_pipe: directed + randomized bench against an in-order ISA-level reference model.
// Latency: n/a (bench).
// Backpressure: bench drives out_ready both steady and randomly toggled.
module tb_riscv_exec_pipe;
    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam bit SCMP  = 1'b1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    riscv_exec_pipe_if #(.XLEN(XLEN)) bus ();

    riscv_exec_pipe #(.XLEN(XLEN), .NREGS(NREGS), .SIGNED_CMP(SCMP)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        bt;
        logic        ill;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mregs [32];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    logic [31:0] obs_res;
    logic        obs_z, obs_bt, obs_ill;
    logic [4:0]  obs_rd;

    task automatic chk1(input string tag, input logic got, input logic want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic chkint(input string tag, input int got, input int want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
    endfunction

    function automatic bit bad(input logic [4:0] r);
        return int'(r) >= NREGS;
    endfunction

    // Reference: instructions retire strictly in program order, one at a time
    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = (i < NREGS) ? 32'(i) : 32'd0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_accept(input logic [31:0] ins);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, imm;
        bit          legal;
        exp_t        e;
        op  = ins[6:0];
        f3  = ins[14:12];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        rd  = ins[11:7];
        a   = mregs[rs1];
        b   = mregs[rs2];
        imm = {{20{ins[31]}}, ins[31:20]};
        e.res = 32'd0; e.z = 1'b0; e.bt = 1'b0; e.ill = 1'b0; e.rd = rd;
        legal = 1'b0;
        case (op)
            7'b0110011: begin
                legal = (f3 <= 3'd4) && !bad(rs1) && !bad(rs2) && !bad(rd);
                case (f3)
                    3'd0:    e.res = a + b;
                    3'd1:    e.res = a - b;
                    3'd2:    e.res = a | b;
                    3'd3:    e.res = a & b;
                    default: e.res = a ^ b;
                endcase
            end
            7'b0010011: begin
                legal = (f3 <= 3'd1) && !bad(rs1) && !bad(rd);
                e.res = (f3 == 3'd0) ? a + imm : a - imm;
            end
            7'b1100011: begin
                legal = (f3 <= 3'd3) && !bad(rs1) && !bad(rs2);
                e.res = a - b;
                case (f3)
                    3'd0:    e.bt = (a == b);
                    3'd1:    e.bt = (a != b);
                    3'd2:    e.bt = SCMP ? ($signed(a) < $signed(b)) : (a < b);
                    default: e.bt = SCMP ? ($signed(a) > $signed(b)) : (a > b);
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.res = 32'd0; e.bt = 1'b0; e.z = 1'b0; e.ill = 1'b1;
        end else begin
            e.z = (e.res == 32'd0);
        end
        if (legal && op != 7'b1100011 && rd != 5'd0) begin
            mregs[rd] = e.res;
        end
        exp_q.push_back(e);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          hi;
        w  = $urandom();
        hi = ($urandom_range(0, 7) == 0) ? 31 : 7;
        case ($urandom_range(0, 9))
            0:       w[6:0] = 7'($urandom_range(0, 127));
            1, 2, 3: begin w[6:0] = 7'b0110011; w[14:12] = 3'($urandom_range(0, 5)); end
            4, 5, 6: begin w[6:0] = 7'b0010011; w[14:12] = 3'($urandom_range(0, 2)); end
            default: begin w[6:0] = 7'b1100011; w[14:12] = 3'($urandom_range(0, 4)); end
        endcase
        w[19:15] = 5'($urandom_range(0, hi));
        w[24:20] = 5'($urandom_range(0, hi));
        w[11:7]  = 5'($urandom_range(0, hi));
        return w;
    endfunction

    // Output checker: every visible result must match the oldest outstanding prediction
    always @(negedge clk) begin
        if (reset_n && bus.out_valid) begin
            chk1("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                chk32("alu_result", bus.alu_result, exp_q[0].res);
                chk1("zero_flag", bus.zero_flag, exp_q[0].z);
                chk1("bt", bus.bt, exp_q[0].bt);
                chk1("illegal", bus.illegal, exp_q[0].ill);
                chk32("rd_out", 32'(bus.rd_out), 32'(exp_q[0].rd));
                if (bus.out_ready) begin
                    obs_res = bus.alu_result;
                    obs_z   = bus.zero_flag;
                    obs_bt  = bus.bt;
                    obs_ill = bus.illegal;
                    obs_rd  = bus.rd_out;
                    n_out++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        if (acc) model_accept(bus.instr);
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        for (int k = 0; k < 20 && !acc; k++) tick(acc);
        chk1("send_accept", acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) tick(acc);
    endtask

    task automatic chk_cleared(input string p);
        chk1({p, "_out_valid"}, bus.out_valid, 1'b0);
        chk32({p, "_alu"}, bus.alu_result, 32'd0);
        chk1({p, "_zero"}, bus.zero_flag, 1'b0);
        chk1({p, "_bt"}, bus.bt, 1'b0);
        chk1({p, "_illegal"}, bus.illegal, 1'b0);
        chk32({p, "_rd"}, 32'(bus.rd_out), 32'd0);
        chk1({p, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [31:0] bp [3];
    bit          acc;
    int          n_acc, idx, out_before;

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        chk_cleared("in_reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk_cleared("post_reset");

        // add x10, x1, x2 with latency probe
        send(enc_r(3'd0, 5'd10, 5'd1, 5'd2));
        chk1("add_valid_after_accept", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk1("add_valid_next_edge", bus.out_valid, 1'b1);
        idle(3);
        chk32("add_res", obs_res, 32'd3);
        chk1("add_zero", obs_z, 1'b0);
        chk1("add_bt", obs_bt, 1'b0);
        chk32("add_rd", 32'(obs_rd), 32'd10);

        send(enc_i(3'd0, 5'd10, 5'd1, 12'd10));
        idle(3);
        chk32("addi_res", obs_res, 32'd11);
        send(enc_i(3'd1, 5'd10, 5'd1, 12'd10));
        idle(3);
        chk32("subi_res", obs_res, 32'hFFFF_FFF7);
        chk1("subi_zero", obs_z, 1'b0);

        // back-to-back dependent pair exercises the bypass
        send(enc_i(3'd0, 5'd5, 5'd0, 12'd7));
        send(enc_r(3'd0, 5'd6, 5'd5, 5'd5));
        idle(3);
        chk32("bypass_res", obs_res, 32'd14);

        send(enc_i(3'd0, 5'd3, 5'd0, 12'hFFF));
        send(enc_b(3'd2, 5'd3, 5'd4));
        idle(3);
        chk1("blt_signed_bt", obs_bt, 1'b1);
        send(enc_b(3'd0, 5'd2, 5'd2));
        idle(3);
        chk1("beq_bt", obs_bt, 1'b1);
        chk1("beq_zero", obs_z, 1'b1);

        // backpressure: three offered while the sink stalls
        bp[0] = enc_i(3'd0, 5'd7, 5'd0, 12'd1);
        bp[1] = enc_i(3'd0, 5'd8, 5'd0, 12'd2);
        bp[2] = enc_i(3'd0, 5'd9, 5'd0, 12'd3);
        bus.out_ready = 1'b0;
        n_acc = 0;
        idx   = 0;
        out_before = n_out;
        bus.in_valid = 1'b1;
        bus.instr    = bp[0];
        for (int c = 0; c < 5; c++) begin
            tick(acc);
            if (acc) begin
                n_acc++;
                idx++;
                if (idx < 3) bus.instr = bp[idx];
                else bus.in_valid = 1'b0;
            end
        end
        chkint("bp_accepted", n_acc, 2);
        chk1("bp_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            tick(acc);
            if (acc) begin
                idx++;
                bus.in_valid = 1'b0;
            end
        end
        chkint("bp_all_accepted", idx, 3);
        idle(4);
        chkint("bp_outputs_once", n_out - out_before, 3);
        chk32("bp_last_res", obs_res, 32'd3);

        // illegal opcode targeting x10 must not disturb it
        send(32'h0000_057F);
        idle(3);
        chk1("illegal_flag", obs_ill, 1'b1);
        chk32("illegal_res", obs_res, 32'd0);
        send(enc_r(3'd0, 5'd11, 5'd10, 5'd0));
        idle(3);
        chk32("illegal_no_write", obs_res, 32'hFFFF_FFF7);

        // register index boundary
        send(enc_r(3'd0, 5'd10, 5'd15, 5'd1));
        idle(3);
        chk1("idx_last_legal", obs_ill, 1'b0);
        chk32("idx_last_res", obs_res, 32'd16);
        send(enc_r(3'd0, 5'd10, 5'd16, 5'd1));
        idle(3);
        chk1("idx_over_illegal", obs_ill, 1'b1);

        // reset with both stages full
        bus.out_ready = 1'b0;
        send(enc_i(3'd0, 5'd10, 5'd0, 12'd99));
        send(enc_i(3'd0, 5'd12, 5'd0, 12'd5));
        chk1("full_out_valid", bus.out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_cleared("mid_reset");
        model_reset();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(enc_r(3'd0, 5'd10, 5'd1, 5'd2));
        idle(3);
        chk32("reset_add_res", obs_res, 32'd3);
        send(enc_r(3'd0, 5'd11, 5'd12, 5'd0));
        idle(3);
        chk32("reset_x12_restored", obs_res, 32'd12);

        // randomized traffic with random sink stalls
        acc = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.instr    = rand_instr();
            end
            tick(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1);
        chkint("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
